bit_serial_multiplier: RTL and testbench

Unsigned shift-add multiplier. The multiplicand arrives in parallel; the multiplier arrives one bit per clock, LSB first, on a serial input. The block accumulates partial products over MULTIPLIER_WIDTH cycles and then raises done with the full-width product. It sits in the bit-serial MAC datapath, feeding the accumulate stage.

---
 rtl/bit_serial_multiplier.sv | 102 ++++++++++
 tb/tb_bit_serial_multiplier.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_multiplier.sv
// Unsigned shift-add multiplier: parallel multiplicand, serial LSB-first multiplier bits.
// Raises done with the full-width product once every multiplier bit has been accumulated.
module bit_serial_multiplier #(
  parameter int MULTIPLICAND_WIDTH = 16,
  parameter int MULTIPLIER_WIDTH   = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [MULTIPLICAND_WIDTH-1:0]              multiplicand,
  input  logic [MULTIPLIER_WIDTH-1:0]                multiplier,
  input  logic                                       multiplier_serial_bit_in,
  output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
  output logic                                       done,
  output logic [1:0]                                 state_dbg
);

  localparam int PW = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
  localparam int CW = $clog2(MULTIPLIER_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [MULTIPLICAND_WIDTH-1:0] m_q, m_d;
  logic [PW-1:0]                 product_q, product_d;
  logic                          done_q, done_d;
  logic                          last_bit;
  logic [PW-1:0]                 addend;

  // The parallel multiplier copy exists only so a bench can see the operand.
  logic unused_multiplier;
  assign unused_multiplier = ^multiplier;

  assign last_bit = (cnt_q == CW'(MULTIPLIER_WIDTH - 1));
  assign addend   = multiplier_serial_bit_in ? (PW'(m_q) << cnt_q) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start wins in every state, so a start during BUSY aborts and restarts.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (MULTIPLIER_WIDTH == 1) ? DONE : BUSY;
    end else begin
      case (state_q)
        BUSY:    state_d = last_bit ? DONE : BUSY;
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    m_d       = m_q;
    product_d = product_q;
    done_d    = done_q;
    if (start) begin
      m_d       = multiplicand;
      product_d = multiplier_serial_bit_in ? PW'(multiplicand) : '0;
      cnt_d     = CW'(1);
      done_d    = (MULTIPLIER_WIDTH == 1);
    end else if (state_q == BUSY) begin
      product_d = product_q + addend;
      cnt_d     = cnt_q + CW'(1);
      if (last_bit) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      m_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product   = product_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bit_serial_multiplier.sv
// Self-checking bench for bit_serial_multiplier at 4x4: directed plan cases plus
// randomized operations checked against plain multiplication of the operands.
module tb_bit_serial_multiplier;

  localparam int MCW = 4;
  localparam int MW  = 4;
  localparam int PW  = MCW + MW;

  logic           clk;
  logic           rst;
  logic           start;
  logic [MCW-1:0] multiplicand;
  logic [MW-1:0]  multiplier;
  logic           multiplier_serial_bit_in;
  logic [PW-1:0]  product;
  logic           done;
  logic [1:0]     state_dbg;

  int tests_run;
  int tests_failed;
  logic [PW-1:0] exp_q[$];

  bit_serial_multiplier #(
    .MULTIPLICAND_WIDTH(MCW),
    .MULTIPLIER_WIDTH  (MW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .multiplicand            (multiplicand),
    .multiplier              (multiplier),
    .multiplier_serial_bit_in(multiplier_serial_bit_in),
    .product                 (product),
    .done                    (done),
    .state_dbg               (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    multiplier_serial_bit_in = 1'b0;
  end

  // Driver: issues one operation starting at the next falling edge. Returns at the
  // falling edge after the last bit was consumed; early_done flags done seen too soon.
  task automatic run_op(input logic [MCW-1:0] m, input logic [MW-1:0] bits,
                        input bit scramble_m, output logic early_done);
    early_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    multiplicand = m;
    multiplier = bits;
    multiplier_serial_bit_in = bits[0];
    for (int i = 1; i < MW; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble_m) multiplicand = MCW'($urandom_range(0, (1 << MCW) - 1));
      multiplier_serial_bit_in = bits[i];
      if (done !== 1'b0) early_done = 1'b1;
    end
    @(negedge clk);
    multiplier_serial_bit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (product !== '0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: product=%h done=%b, want product=00 done=0", product, done);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      multiplier_serial_bit_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if (product !== '0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_after_reset[%0d]: product=%h done=%b, want 00/0", i, product, done);
      end
    end
  endtask

  // Directed operand pairs from the plan; expectations are written as constants.
  task automatic test_directed();
    logic [MCW-1:0] ms[4]  = '{4'h2, 4'hF, 4'h0, 4'hF};
    logic [MW-1:0]  bs[4]  = '{4'b0110, 4'b1111, 4'b1101, 4'b0000};
    logic [PW-1:0]  exp[4] = '{8'h0C, 8'hE1, 8'h00, 8'h00};
    logic early;
    for (int k = 0; k < 4; k++) begin
      run_op(ms[k], bs[k], (k == 0), early);
      tests_run++;
      if (early || done !== 1'b1 || product !== exp[k]) begin
        tests_failed++;
        $display("FAIL directed[%0d]: product=%h done=%b early=%b, want product=%h done=1",
                 k, product, done, early, exp[k]);
      end
      if (k == 0) begin
        multiplicand = '0;
        for (int h = 0; h < 3; h++) begin
          multiplier_serial_bit_in = 1'($urandom_range(0, 1));
          @(negedge clk);
          tests_run++;
          if (product !== 8'h0C || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_hold[%0d]: product=%h done=%b, want 0c/1", h, product, done);
          end
        end
      end
    end
  endtask

  task automatic test_restart();
    logic early;
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'h5;
    multiplier_serial_bit_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    multiplier_serial_bit_in = 1'b1;
    run_op(4'h3, 4'b0101, 1'b0, early);
    tests_run++;
    if (early || done !== 1'b1 || product !== 8'h0F) begin
      tests_failed++;
      $display("FAIL restart: product=%h done=%b early=%b, want 0f/1", product, done, early);
    end
  endtask

  task automatic test_reset_mid_op();
    logic early;
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'hF;
    multiplier_serial_bit_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (product !== '0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: product=%h done=%b, want 00/0", product, done);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(4'h7, 4'h9, 1'b1, early);
    tests_run++;
    if (early || done !== 1'b1 || product !== 8'h3F) begin
      tests_failed++;
      $display("FAIL after_reset_op: product=%h done=%b early=%b, want 3f/1", product, done, early);
    end
  endtask

  // Randomized operations, some back-to-back and some after idle gaps; the
  // reference is ordinary integer multiplication queued into exp_q.
  task automatic test_random();
    logic early;
    logic [MCW-1:0] m;
    logic [MW-1:0]  b;
    logic [PW-1:0]  exp;
    for (int n = 0; n < 40; n++) begin
      m = MCW'($urandom_range(0, (1 << MCW) - 1));
      b = MW'($urandom_range(0, (1 << MW) - 1));
      if (n % 8 == 0) begin
        m = '1;
        b = '1;
      end
      exp_q.push_back(PW'(int'(m) * int'(b)));
      run_op(m, b, 1'b1, early);
      exp = exp_q.pop_front();
      tests_run++;
      if (early || done !== 1'b1 || product !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] %h*%h: product=%h done=%b early=%b, want %h/1",
                 n, m, b, product, done, early, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_restart();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
